// File: rtl/sdram_func_module.sv
// sdram_func_module: single-access SDRAM command sequencer for write, read (auto precharge) and auto refresh.
// All outputs are registered; a command appears on the pins the cycle after its state is decided.
module sdram_func_module #(
   parameter int TRCD = 2,
   parameter int TCL  = 3,
   parameter int TWR  = 2,
   parameter int TRP  = 2,
   parameter int TRFC = 7
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic [2:0]  Func_Start_Sig,
   input  logic [21:0] Addr,
   input  logic [15:0] WrData,
   input  logic [15:0] SDRAM_DQ_In,
   output logic        Func_Done_Sig,
   output logic        AR_Done_Sig,
   output logic [15:0] RdData,
   output logic [3:0]  SDRAM_CMD,
   output logic [1:0]  SDRAM_BA,
   output logic [11:0] SDRAM_A,
   output logic [15:0] SDRAM_DQ_Out,
   output logic        SDRAM_DQ_OE
);
   localparam logic [3:0] CMD_NOP   = 4'b0111;
   localparam logic [3:0] CMD_ACT   = 4'b0011;
   localparam logic [3:0] CMD_READ  = 4'b0101;
   localparam logic [3:0] CMD_WRITE = 4'b0100;
   localparam logic [3:0] CMD_AREF  = 4'b0001;
   localparam int M_A     = TRCD > TRFC ? TRCD : TRFC;
   localparam int M_B     = (TCL + TRP) > (TWR + TRP) ? (TCL + TRP) : (TWR + TRP);
   localparam int CNT_MAX = M_A > M_B ? M_A : M_B;
   localparam int CW      = $clog2(CNT_MAX + 1);
   typedef enum logic [3:0] {IDLE, ACT, RCD_WAIT, WR, RD, RD_WAIT, WR_WAIT, AREF, RFC_WAIT, DONE, AR_DONE} state_t;
   state_t        state;
   logic [CW-1:0] cnt;
   logic          is_rd;
   logic [7:0]    col_q;
   logic [15:0]   wr_q;
   // cnt counts cycles since the last issued command; each wait exits on its final NOP cycle
   always_ff @(posedge CLK) begin
      if (RST) begin
         state         <= IDLE;
         cnt           <= '0;
         is_rd         <= 1'b0;
         col_q         <= '0;
         wr_q          <= '0;
         SDRAM_CMD     <= CMD_NOP;
         SDRAM_BA      <= '0;
         SDRAM_A       <= '0;
         SDRAM_DQ_Out  <= '0;
         SDRAM_DQ_OE   <= 1'b0;
         RdData        <= '0;
         Func_Done_Sig <= 1'b0;
         AR_Done_Sig   <= 1'b0;
      end else begin
         SDRAM_CMD     <= CMD_NOP;
         SDRAM_DQ_OE   <= 1'b0;
         Func_Done_Sig <= 1'b0;
         AR_Done_Sig   <= 1'b0;
         case (state)
            IDLE: begin
               cnt <= '0;
               if (Func_Start_Sig != 3'b000) begin
                  is_rd <= Func_Start_Sig[1];
                  col_q <= Addr[7:0];
                  wr_q  <= WrData;
               end
               if (Func_Start_Sig[2]) begin
                  state     <= AREF;
                  SDRAM_CMD <= CMD_AREF;
               end else if (Func_Start_Sig[1:0] != 2'b00) begin
                  state     <= ACT;
                  SDRAM_CMD <= CMD_ACT;
                  SDRAM_BA  <= Addr[21:20];
                  SDRAM_A   <= Addr[19:8];
               end
            end
            ACT, RCD_WAIT: begin
               if (cnt == CW'(TRCD - 1)) begin
                  state       <= is_rd ? RD : WR;
                  SDRAM_CMD   <= is_rd ? CMD_READ : CMD_WRITE;
                  SDRAM_A     <= {4'b0100, col_q};
                  SDRAM_DQ_OE <= ~is_rd;
                  cnt         <= '0;
                  if (!is_rd) SDRAM_DQ_Out <= wr_q;
               end else begin
                  state <= RCD_WAIT;
                  cnt   <= cnt + 1'b1;
               end
            end
            WR, WR_WAIT: begin
               if (cnt == CW'(TWR + TRP)) begin
                  state         <= DONE;
                  Func_Done_Sig <= 1'b1;
               end else begin
                  state <= WR_WAIT;
                  cnt   <= cnt + 1'b1;
               end
            end
            RD, RD_WAIT: begin
               if (cnt == CW'(TCL)) RdData <= SDRAM_DQ_In;
               if (cnt == CW'(TCL + TRP)) begin
                  state         <= DONE;
                  Func_Done_Sig <= 1'b1;
               end else begin
                  state <= RD_WAIT;
                  cnt   <= cnt + 1'b1;
               end
            end
            AREF, RFC_WAIT: begin
               if (cnt == CW'(TRFC - 1)) begin
                  state       <= AR_DONE;
                  AR_Done_Sig <= 1'b1;
               end else begin
                  state <= RFC_WAIT;
                  cnt   <= cnt + 1'b1;
               end
            end
            DONE, AR_DONE: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_sdram_func_module.sv
// tb_sdram_func_module: randomized operation stream checked cycle by cycle against a timeline model.
// The model derives each expected pin value from the operation kind and the timing parameters.
module tb_sdram_func_module;
   localparam int TRCD = 2;
   localparam int TCL  = 3;
   localparam int TWR  = 2;
   localparam int TRP  = 2;
   localparam int TRFC = 7;
   localparam logic [3:0] NOP   = 4'b0111;
   localparam logic [3:0] ACT   = 4'b0011;
   localparam logic [3:0] READ  = 4'b0101;
   localparam logic [3:0] WRITE = 4'b0100;
   localparam logic [3:0] AREF  = 4'b0001;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic [2:0]  Func_Start_Sig = '0;
   logic [21:0] Addr = '0;
   logic [15:0] WrData = '0;
   logic [15:0] SDRAM_DQ_In = '0;
   logic        Func_Done_Sig;
   logic        AR_Done_Sig;
   logic [15:0] RdData;
   logic [3:0]  SDRAM_CMD;
   logic [1:0]  SDRAM_BA;
   logic [11:0] SDRAM_A;
   logic [15:0] SDRAM_DQ_Out;
   logic        SDRAM_DQ_OE;

   int          n_cmp = 0;
   int          n_err = 0;
   logic [15:0] exp_rd = '0;

   sdram_func_module #(.TRCD(TRCD), .TCL(TCL), .TWR(TWR), .TRP(TRP), .TRFC(TRFC)) dut (
      .CLK(CLK), .RST(RST), .Func_Start_Sig(Func_Start_Sig), .Addr(Addr), .WrData(WrData),
      .SDRAM_DQ_In(SDRAM_DQ_In), .Func_Done_Sig(Func_Done_Sig), .AR_Done_Sig(AR_Done_Sig),
      .RdData(RdData), .SDRAM_CMD(SDRAM_CMD), .SDRAM_BA(SDRAM_BA), .SDRAM_A(SDRAM_A),
      .SDRAM_DQ_Out(SDRAM_DQ_Out), .SDRAM_DQ_OE(SDRAM_DQ_OE)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   // Drives one request in the current (idle) cycle, then checks every following cycle.
   task automatic run_op(input logic [2:0] op, input logic [21:0] ad, input logic [15:0] wd, input logic [15:0] rv);
      int kind;
      int cmd_k;
      int cap_k;
      int last;
      logic [11:0] col_a;
      logic [11:0] row_a;
      logic [3:0]  ec;
      logic [15:0] er;
      kind  = op[2] ? 2 : (op[1] ? 1 : 0);
      cmd_k = 1 + TRCD;
      cap_k = cmd_k + TCL;
      last  = (kind == 2) ? 1 + TRFC : (kind == 1 ? cmd_k + TCL + TRP + 1 : cmd_k + TWR + TRP + 1);
      row_a = ad[19:8];
      col_a = {4'b0100, ad[7:0]};
      Func_Start_Sig = op;
      Addr = ad;
      WrData = wd;
      for (int k = 1; k <= last; k++) begin
         tick();
         ec = NOP;
         if (k == 1) ec = (kind == 2) ? AREF : ACT;
         else if (kind != 2 && k == cmd_k) ec = (kind == 1) ? READ : WRITE;
         er = (kind == 1 && k > cap_k) ? rv : exp_rd;
         chk("cmd", 32'(SDRAM_CMD), 32'(ec));
         chk("func_done", 32'(Func_Done_Sig), 32'(kind != 2 && k == last));
         chk("ar_done", 32'(AR_Done_Sig), 32'(kind == 2 && k == last));
         chk("dq_oe", 32'(SDRAM_DQ_OE), 32'(kind == 0 && k == cmd_k));
         chk("rddata", 32'(RdData), 32'(er));
         if (kind != 2) begin
            chk("ba", 32'(SDRAM_BA), 32'(ad[21:20]));
            chk("a", 32'(SDRAM_A), 32'(k < cmd_k ? row_a : col_a));
         end
         if (kind == 0 && k == cmd_k) chk("dq_out", 32'(SDRAM_DQ_Out), 32'(wd));
         SDRAM_DQ_In = (kind == 1 && k == cap_k) ? rv : 16'($urandom);
         if (k == last) Func_Start_Sig = '0;
      end
      if (kind == 1) exp_rd = rv;
      tick();
      chk("idle_cmd", 32'(SDRAM_CMD), 32'(NOP));
      chk("idle_done", 32'({Func_Done_Sig, AR_Done_Sig}), 32'(0));
      chk("idle_rddata", 32'(RdData), 32'(exp_rd));
   endtask

   initial begin
      repeat (3) tick();
      chk("rst_cmd", 32'(SDRAM_CMD), 32'(NOP));
      chk("rst_ba_a", 32'({SDRAM_BA, SDRAM_A}), 32'(0));
      chk("rst_dq", 32'({SDRAM_DQ_Out, SDRAM_DQ_OE}), 32'(0));
      chk("rst_rddata", 32'(RdData), 32'(0));
      chk("rst_done", 32'({Func_Done_Sig, AR_Done_Sig}), 32'(0));
      RST = 1'b0;
      tick();
      run_op(3'b001, 22'h12A53C, 16'hBEEF, 16'h0000);
      run_op(3'b010, 22'h12A53C, 16'h0000, 16'h1234);
      run_op(3'b100, 22'h000000, 16'h0000, 16'h0000);
      run_op(3'b111, 22'h3FFFFF, 16'hFFFF, 16'h5555);
      run_op(3'b011, 22'h2ABCFF, 16'hA5A5, 16'hC3C3);
      run_op(3'b010, 22'h000000, 16'h0000, 16'hFFFF);
      for (int i = 0; i < 30; i++) begin
         logic [2:0] op;
         op = 3'($urandom_range(1, 7));
         run_op(op, 22'($urandom), 16'($urandom), 16'($urandom));
      end
      run_op(3'b010, 22'h155555, 16'h0000, 16'h7E81);
      Func_Start_Sig = 3'b001;
      Addr = 22'h0ABCDE;
      WrData = 16'h1357;
      tick();
      chk("rst_mid_act", 32'(SDRAM_CMD), 32'(ACT));
      tick();
      chk("rst_mid_nop", 32'(SDRAM_CMD), 32'(NOP));
      RST = 1'b1;
      tick();
      chk("rst_abort_cmd", 32'(SDRAM_CMD), 32'(NOP));
      chk("rst_abort_oe", 32'(SDRAM_DQ_OE), 32'(0));
      chk("rst_abort_rddata", 32'(RdData), 32'(0));
      chk("rst_abort_ba_a", 32'({SDRAM_BA, SDRAM_A}), 32'(0));
      RST = 1'b0;
      Func_Start_Sig = '0;
      exp_rd = '0;
      for (int i = 0; i < 12; i++) begin
         tick();
         chk("post_rst_cmd", 32'(SDRAM_CMD), 32'(NOP));
         chk("post_rst_done", 32'({Func_Done_Sig, AR_Done_Sig}), 32'(0));
      end
      run_op(3'b001, 22'h0ABCDE, 16'h2468, 16'h0000);
      run_op(3'b010, 22'h0ABCDE, 16'h0000, 16'h9ABC);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
